// File: rtl/packet_serial_tx.sv
// packet_serial_tx: serializes a framed packet onto a single-wire bus,
// waits for the receiver's ack/nack, and retransmits from a shadow copy
// on nack or timeout until the retry budget is spent.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | line high, ready for a request; bad framing pulses frame_err
// SHIFT    | frame on the line MSB-first, each bit held BIT_DIV cycles
// WAIT_ACK | line high, ack timer running, waiting for ack/nack
module packet_serial_tx #(
  parameter int PKT_W       = 79,
  parameter int BIT_DIV     = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRY   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PKT_W-1:0] packet_in,
  input  logic             send,
  output logic             ready,
  output logic             busy,
  output logic             tx_line,
  input  logic             ack_in,
  input  logic             nack_in,
  output logic             done,
  output logic             fail,
  output logic             frame_err,
  output logic [1:0]       retry_count
);

  localparam int IDX_W = $clog2(PKT_W);
  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT);

  localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(PKT_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  state_e             state_q;
  logic [PKT_W-1:0]   shadow_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic [DIV_W-1:0]   div_q;
  logic [TMR_W-1:0]   tmr_q;
  logic               tx_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic               fail_q;
  logic               frame_err_q;
  logic [1:0]         retry_q;

  logic [IDX_W-1:0]   bit_idx_d;
  logic               frame_ok;
  logic               ack_ok;
  logic               retx_req;

  // Decode of the request framing and the receiver response.
  always_comb begin
    bit_idx_d = bit_idx_q - IDX_W'(1);
    frame_ok  = (packet_in[PKT_W-1] == 1'b0) && (packet_in[0] == 1'b1);
    ack_ok    = ack_in && !nack_in;
    retx_req  = nack_in || (tmr_q == TMR_LAST);
  end

  // Control FSM: sequencing, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      div_q       <= '0;
      tmr_q       <= '0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      frame_err_q <= 1'b0;
      retry_q     <= 2'd0;
    end else begin
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (send) begin
            if (frame_ok) begin
              shadow_q  <= packet_in;
              tx_q      <= packet_in[PKT_W-1];
              retry_q   <= 2'd0;
              busy_q    <= 1'b1;
              ready_q   <= 1'b0;
              bit_idx_q <= IDX_MSB;
              div_q     <= '0;
              state_q   <= SHIFT;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bit_idx_q == '0) begin
              tx_q    <= 1'b1;
              tmr_q   <= '0;
              state_q <= WAIT_ACK;
            end else begin
              bit_idx_q <= bit_idx_d;
              tx_q      <= shadow_q[bit_idx_d];
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        WAIT_ACK: begin
          if (ack_ok) begin
            tmr_q   <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (retx_req) begin
            tmr_q <= '0;
            if (retry_q < RETRY_MAX) begin
              // Retransmit straight from the untouched shadow copy.
              retry_q   <= retry_q + 2'd1;
              tx_q      <= shadow_q[PKT_W-1];
              bit_idx_q <= IDX_MSB;
              div_q     <= '0;
              state_q   <= SHIFT;
            end else begin
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready       = ready_q;
  assign busy        = busy_q;
  assign tx_line     = tx_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign frame_err   = frame_err_q;
  assign retry_count = retry_q;

endmodule
